// File: rtl/branch_sequencer.sv
// branch_sequencer: execute-phase sequencer for conditional branch instructions.
// After fetch has loaded IR, a start request walks CHECK -> ADDR -> SUM -> WRITE
// -> DONE. Each state drives the control strobes for one datapath step. The PC
// load in WRITE is gated by the condition flip-flop output (con_q).
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   start, IR             execute request and instruction register contents
//   con_q                 condition flip-flop output (must be valid in WRITE)
//   stall, abort          freeze the sequencer / flush it back to IDLE
//   Grb..PCin             datapath control strobes (decoded from state)
//   con_bits              C2 field latched when start is accepted
//   busy, done            sequencer active / one-cycle completion pulse
//   taken, illegal        last branch result / non-branch opcode pulse
//   taken_count,
//   nottaken_count        saturating branch statistics (BRANCH_STATS_EN only)
//
// Build option: define BRANCH_STATS_EN to add the statistics counters.
module branch_sequencer #(
  parameter logic [4:0] BR_OPCODE = 5'b10010
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] IR,
  input  logic        con_q,
  input  logic        stall,
  input  logic        abort,
  output logic        Grb,
  output logic        Rout,
  output logic        BAout,
  output logic        CONin,
  output logic        PCout,
  output logic        Yin,
  output logic        Cout,
  output logic        alu_add,
  output logic        Zin,
  output logic        Zlowout,
  output logic        PCin,
  output logic [1:0]  con_bits,
  output logic        busy,
  output logic        done,
  output logic        taken,
  output logic        illegal
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0] taken_count,
  output logic [15:0] nottaken_count
`endif
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    ADDR  = 3'd2,
    SUM   = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t state;
  state_t next_state;

  logic is_branch;
  logic accept;
  logic leave_write;
  logic unused_ir;

  assign is_branch   = (IR[31:27] == BR_OPCODE);
  // start is only honoured in IDLE when the sequencer is neither frozen nor flushed
  assign accept      = (state == IDLE) && start && !stall && !abort;
  assign leave_write = (state == WRITE) && !stall && !abort;
  assign unused_ir   = ^{IR[26:21], IR[18:0]};

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next state and strobe decode; stall masks load enables, not bus drives
  always_comb begin
    next_state = state;
    Grb        = 1'b0;
    Rout       = 1'b0;
    BAout      = 1'b0;
    CONin      = 1'b0;
    PCout      = 1'b0;
    Yin        = 1'b0;
    Cout       = 1'b0;
    alu_add    = 1'b0;
    Zin        = 1'b0;
    Zlowout    = 1'b0;
    PCin       = 1'b0;
    done       = 1'b0;
    busy       = (state != IDLE);

    case (state)
      IDLE: begin
        if (accept && is_branch) next_state = CHECK;
      end
      CHECK: begin
        Grb   = 1'b1;
        Rout  = 1'b1;
        BAout = 1'b1;
        CONin = !stall;
        if (!stall) next_state = ADDR;
      end
      ADDR: begin
        PCout = 1'b1;
        Yin   = !stall;
        if (!stall) next_state = SUM;
      end
      SUM: begin
        Cout    = 1'b1;
        alu_add = 1'b1;
        Zin     = !stall;
        if (!stall) next_state = WRITE;
      end
      WRITE: begin
        Zlowout = 1'b1;
        // a flush or reset in WRITE must not commit the PC
        PCin    = con_q && !stall && !abort && !reset;
        if (!stall) next_state = DONE;
      end
      DONE: begin
        done = !stall;
        if (!stall) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase

    if (abort) next_state = IDLE;
  end

  // Registered status: latched condition field, branch result, illegal pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      con_bits <= 2'b00;
      taken    <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      illegal <= accept && !is_branch;
      if (accept)      con_bits <= IR[20:19];
      if (leave_write) taken    <= con_q;
    end
  end

`ifdef BRANCH_STATS_EN
  // Saturating outcome counters, updated as WRITE completes
  always_ff @(posedge clock) begin
    if (reset) begin
      taken_count    <= '0;
      nottaken_count <= '0;
    end else if (leave_write) begin
      if (con_q) begin
        if (taken_count != {CNT_W{1'b1}}) taken_count <= taken_count + CNT_W'(1);
      end else begin
        if (nottaken_count != {CNT_W{1'b1}}) nottaken_count <= nottaken_count + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// tb_branch_sequencer: self-checking bench for branch_sequencer. Each scenario
// task queues the expected per-cycle strobe vectors, then pops one per cycle
// and compares it with the sampled DUT outputs.
// Vector bit order: Grb Rout BAout CONin PCout Yin Cout alu_add Zin Zlowout PCin busy done
module tb_branch_sequencer;

  localparam logic [4:0] BR = 5'b10010;

  localparam logic [12:0] V_IDL  = 13'b0000000000000;
  localparam logic [12:0] V_CHK  = 13'b1111000000010;
  localparam logic [12:0] V_ADR  = 13'b0000110000010;
  localparam logic [12:0] V_SUM  = 13'b0000001110010;
  localparam logic [12:0] V_SUMS = 13'b0000001100010;
  localparam logic [12:0] V_WRT  = 13'b0000000001110;
  localparam logic [12:0] V_WRN  = 13'b0000000001010;
  localparam logic [12:0] V_DON  = 13'b0000000000011;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] IR;
  logic        con_q;
  logic        stall;
  logic        abort;
  logic        Grb, Rout, BAout, CONin, PCout, Yin, Cout, alu_add, Zin, Zlowout, PCin;
  logic [1:0]  con_bits;
  logic        busy, done, taken, illegal;
`ifdef BRANCH_STATS_EN
  logic [15:0] taken_count, nottaken_count;
`endif

  int total = 0;
  int bad   = 0;
  logic [12:0] exp_q[$];
  logic [12:0] obs;
  logic [12:0] expv;

  always #5 clock = ~clock;

  branch_sequencer #(.BR_OPCODE(BR)) dut (
    .clock(clock), .reset(reset), .start(start), .IR(IR), .con_q(con_q),
    .stall(stall), .abort(abort),
    .Grb(Grb), .Rout(Rout), .BAout(BAout), .CONin(CONin), .PCout(PCout),
    .Yin(Yin), .Cout(Cout), .alu_add(alu_add), .Zin(Zin), .Zlowout(Zlowout),
    .PCin(PCin), .con_bits(con_bits), .busy(busy), .done(done),
    .taken(taken), .illegal(illegal)
`ifdef BRANCH_STATS_EN
    , .taken_count(taken_count), .nottaken_count(nottaken_count)
`endif
  );

  function automatic logic [12:0] vec();
    return {Grb, Rout, BAout, CONin, PCout, Yin, Cout, alu_add, Zin, Zlowout, PCin, busy, done};
  endfunction

  function automatic logic [31:0] make_ir(input logic [4:0] op, input logic [1:0] c2);
    logic [31:0] r;
    r = $urandom;
    r[31:27] = op;
    r[20:19] = c2;
    return r;
  endfunction

  task automatic test_reset();
    total++;
    if (vec() !== V_IDL) begin bad++; $display("FAIL reset_strobes got=%b want=%b", vec(), V_IDL); end
    total++;
    if ({con_bits, taken, illegal} !== 4'b0000) begin
      bad++; $display("FAIL reset_regs got=%b want=0000", {con_bits, taken, illegal});
    end
  endtask

  task automatic test_taken();
    IR = make_ir(BR, 2'b00); con_q = 1'b1; start = 1'b1;
    exp_q = '{V_CHK, V_ADR, V_SUM, V_WRT, V_DON, V_IDL};
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1 start = 1'b0; #1;
      obs = vec(); expv = exp_q.pop_front(); total++;
      if (obs !== expv) begin bad++; $display("FAIL taken_seq cyc=%0d got=%b want=%b", i, obs, expv); end
    end
    total++;
    if (taken !== 1'b1 || con_bits !== 2'b00) begin
      bad++; $display("FAIL taken_result taken=%b con_bits=%b want 1/00", taken, con_bits);
    end
  endtask

  task automatic test_not_taken();
    IR = make_ir(BR, 2'b10); con_q = 1'b0; start = 1'b1;
    exp_q = '{V_CHK, V_ADR, V_SUM, V_WRN, V_DON, V_IDL};
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1 start = 1'b0; #1;
      obs = vec(); expv = exp_q.pop_front(); total++;
      if (obs !== expv) begin bad++; $display("FAIL nottaken_seq cyc=%0d got=%b want=%b", i, obs, expv); end
    end
    total++;
    if (taken !== 1'b0 || con_bits !== 2'b10) begin
      bad++; $display("FAIL nottaken_result taken=%b con_bits=%b want 0/10", taken, con_bits);
    end
`ifdef BRANCH_STATS_EN
    total++;
    if (nottaken_count !== 16'd1 || taken_count !== 16'd1) begin
      bad++; $display("FAIL stats_after_nottaken t=%0d nt=%0d want 1/1", taken_count, nottaken_count);
    end
`endif
  endtask

  task automatic test_illegal();
    IR = make_ir(5'b00011, 2'b01); con_q = 1'b1; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1 start = 1'b0; #1;
      total++;
      if (vec() !== V_IDL || illegal !== (i == 0)) begin
        bad++; $display("FAIL illegal cyc=%0d strobes=%b illegal=%b want strobes=0 illegal=%b",
                        i, vec(), illegal, (i == 0));
      end
    end
    total++;
    if (con_bits !== 2'b01) begin bad++; $display("FAIL illegal_con_bits got=%b want=01", con_bits); end
  endtask

  task automatic test_stall();
    IR = make_ir(BR, 2'b00); con_q = 1'b1; start = 1'b1;
    exp_q = '{V_CHK, V_ADR, V_SUMS, V_SUMS, V_SUMS, V_SUM, V_WRT, V_DON, V_IDL};
    for (int i = 0; i < 9; i++) begin
      @(posedge clock); #1 start = 1'b0; stall = (i >= 2 && i <= 4); #1;
      obs = vec(); expv = exp_q.pop_front(); total++;
      if (obs !== expv) begin bad++; $display("FAIL stall_seq cyc=%0d got=%b want=%b", i, obs, expv); end
    end
    stall = 1'b0;
    total++;
    if (taken !== 1'b1) begin bad++; $display("FAIL stall_taken got=%b want=1", taken); end
  endtask

  task automatic test_abort();
    IR = make_ir(BR, 2'b11); con_q = 1'b1; start = 1'b1;
    exp_q = '{V_CHK, V_ADR, V_SUM, V_IDL, V_IDL};
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1 start = 1'b0; abort = (i == 2); con_q = (i < 2); #1;
      obs = vec(); expv = exp_q.pop_front(); total++;
      if (obs !== expv) begin bad++; $display("FAIL abort_seq cyc=%0d got=%b want=%b", i, obs, expv); end
    end
    abort = 1'b0;
    total++;
    if (taken !== 1'b1) begin bad++; $display("FAIL abort_taken got=%b want=1", taken); end
  endtask

  task automatic test_reset_in_write();
    IR = make_ir(BR, 2'b11); con_q = 1'b1; start = 1'b1;
    exp_q = '{V_CHK, V_ADR, V_SUM, V_WRN, V_IDL};
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1 start = 1'b0; reset = (i == 3); #1;
      obs = vec(); expv = exp_q.pop_front(); total++;
      if (obs !== expv) begin bad++; $display("FAIL rstw_seq cyc=%0d got=%b want=%b", i, obs, expv); end
    end
    total++;
    if ({con_bits, taken, illegal} !== 4'b0000) begin
      bad++; $display("FAIL rstw_regs got=%b want=0000", {con_bits, taken, illegal});
    end
    IR = make_ir(BR, 2'b01); con_q = 1'b1; start = 1'b1;
    exp_q = '{V_CHK, V_ADR, V_SUM, V_WRT, V_DON, V_IDL};
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1 start = 1'b0; #1;
      obs = vec(); expv = exp_q.pop_front(); total++;
      if (obs !== expv) begin bad++; $display("FAIL rstw_rerun cyc=%0d got=%b want=%b", i, obs, expv); end
    end
    total++;
    if (taken !== 1'b1 || con_bits !== 2'b01) begin
      bad++; $display("FAIL rstw_rerun_result taken=%b con_bits=%b want 1/01", taken, con_bits);
    end
  endtask

  task automatic test_back_to_back();
    IR = make_ir(BR, 2'b10); con_q = 1'b0; start = 1'b1;
    exp_q = '{V_CHK, V_ADR, V_SUM, V_WRN, V_DON, V_IDL,
              V_CHK, V_ADR, V_SUM, V_WRN, V_DON, V_IDL};
    for (int i = 0; i < 12; i++) begin
      @(posedge clock); #1 start = (i <= 5); #1;
      obs = vec(); expv = exp_q.pop_front(); total++;
      if (obs !== expv) begin bad++; $display("FAIL b2b_seq cyc=%0d got=%b want=%b", i, obs, expv); end
    end
    start = 1'b0;
`ifdef BRANCH_STATS_EN
    total++;
    if (taken_count !== 16'd1 || nottaken_count !== 16'd2) begin
      bad++; $display("FAIL stats_final t=%0d nt=%0d want 1/2", taken_count, nottaken_count);
    end
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; IR = '0; con_q = 1'b0; stall = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0; #1;
    test_reset();
    test_taken();
    test_not_taken();
    test_illegal();
    test_stall();
    test_abort();
    test_reset_in_write();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
